// File: rtl/bus_arbiter.sv
// bus_arbiter: grants one of N requesters the shared system bus and
// sequences a single read or write access with WAIT extra strobe cycles.
// Ports:
//   _CLK, RST     clock, synchronous active-high reset
//   REQ, WE       per-channel request level and direction (1 = write)
//   ADDR, WDATA   per-channel address / write data, channel i in [i*W +: W]
//   GNT, ACK      one-hot grant (whole strobe) and one-cycle completion pulse
//   RDATA         last completed read data
//   BUSY          high while an access is in progress
//   BUS_A/D/R/W   system bus address, data (tristate), read and write strobes
module bus_arbiter #(
  parameter int N    = 2,
  parameter int AW   = 23,
  parameter int DW   = 16,
  parameter int WAIT = 1,
  parameter int MODE = 0
) (
  input  logic            _CLK,
  input  logic            RST,
  input  logic [N-1:0]    REQ,
  input  logic [N-1:0]    WE,
  input  logic [N*AW-1:0] ADDR,
  input  logic [N*DW-1:0] WDATA,
  output logic [N-1:0]    GNT,
  output logic [N-1:0]    ACK,
  output logic [DW-1:0]   RDATA,
  output logic            BUSY,
  output logic [AW-1:0]   BUS_A,
  inout  wire  [DW-1:0]   BUS_D,
  output logic            BUS_R,
  output logic            BUS_W
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STROBE,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [N-1:0]    ack_q, ack_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [AW-1:0]   bus_a_q, bus_a_d;
  logic            bus_r_q, bus_r_d;
  logic            bus_w_q, bus_w_d;

  logic            any_req;
  logic [PW-1:0]   win;
  int              idx;

  // Winner search. Fixed priority scans from 0; round-robin scans
  // from the channel after the last winner and wraps.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
      idx = (MODE != 0) ? (int'(ptr_q) + 1 + i) % N : i;
      if (!any_req && REQ[idx]) begin
        any_req = 1'b1;
        win     = PW'(idx);
      end
    end
  end

  wire last_strobe = (state_q == S_STROBE) && (cnt_q == '0);

  // State register
  always_ff @(posedge _CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= PW'(N - 1);
      gnt_q   <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
      wdata_q <= '0;
      bus_a_q <= '0;
      bus_r_q <= 1'b0;
      bus_w_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
      bus_a_q <= bus_a_d;
      bus_r_q <= bus_r_d;
      bus_w_q <= bus_w_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_STROBE;
          cnt_d   = CW'(WAIT);
        end
      end
      S_STROBE: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    rdata_d = rdata_q;
    wdata_d = wdata_q;
    bus_a_d = bus_a_q;
    bus_r_d = bus_r_q;
    bus_w_d = bus_w_q;
    if (state_q == S_IDLE && any_req) begin
      ptr_d      = win;
      gnt_d      = '0;
      gnt_d[win] = 1'b1;
      bus_a_d    = ADDR[int'(win)*AW +: AW];
      wdata_d    = WDATA[int'(win)*DW +: DW];
      bus_r_d    = ~WE[win];
      bus_w_d    = WE[win];
    end else if (last_strobe) begin
      if (bus_r_q) rdata_d = BUS_D;
      ack_d   = gnt_q;
      gnt_d   = '0;
      bus_a_d = '0;
      bus_r_d = 1'b0;
      bus_w_d = 1'b0;
    end
  end

  assign GNT   = gnt_q;
  assign ACK   = ack_q;
  assign RDATA = rdata_q;
  assign BUSY  = (state_q != S_IDLE);
  assign BUS_A = bus_a_q;
  assign BUS_R = bus_r_q;
  assign BUS_W = bus_w_q;
  assign BUS_D = bus_w_q ? wdata_q : {DW{1'bz}};

  a_rw_excl: assert property (@(posedge _CLK) disable iff (RST)
    !(BUS_R && BUS_W));
  a_gnt_oh: assert property (@(posedge _CLK) disable iff (RST)
    $onehot0(GNT));
  a_ack_oh: assert property (@(posedge _CLK) disable iff (RST)
    $onehot0(ACK));
  a_gnt_ack: assert property (@(posedge _CLK) disable iff (RST)
    !((|GNT) && (|ACK)));

endmodule
